// File: rtl/aq_pad_decoder.sv
// Aquarius hand-controller decoder: synchronises and debounces the raw active-low pad byte,
// decodes it to MiST joystick bits and queues every change of the decoded state in a small FIFO.
module aq_pad_decoder #(
  parameter int SAMPLE_DIV = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pad_in,
  output logic [7:0] joy_out,
  output logic       evt_valid,
  output logic [7:0] evt_data,
  input  logic       evt_ready,
  output logic       evt_overflow
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE);
  localparam logic [AW:0]   FIFO_CAP = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [CW-1:0] r_div;
  logic [7:0]    r_cand;
  logic [DW-1:0] r_cnt;
  logic [7:0]    r_accepted;
  logic [7:0]    r_joy;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          r_overflow;

  logic          w_strobe;
  logic [7:0]    w_cand_nxt;
  logic [DW-1:0] w_cnt_nxt;
  logic          w_take;
  logic [7:0]    w_p;
  logic [7:0]    w_dec;
  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;

  assign w_strobe = (r_div == DIV_LAST);

  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (w_strobe) begin
      if (r_sync2 != r_cand) begin
        w_cand_nxt = r_sync2;
        w_cnt_nxt  = DW'(1);
      end else if (r_cnt != DB_MAX) begin
        w_cnt_nxt = r_cnt + DW'(1);
      end
    end
  end

  // Re-accepting the same value on every saturated strobe is harmless.
  assign w_take = w_strobe && (w_cnt_nxt == DB_MAX);

  // Bit 7 turns the shared lines 5 and 2 into X/Y instead of B/up.
  assign w_p = ~r_accepted;
  always_comb begin
    w_dec    = '0;
    w_dec[0] = w_p[1];
    w_dec[1] = w_p[3];
    w_dec[2] = w_p[0];
    w_dec[3] = w_p[2] & ~w_p[7];
    w_dec[4] = w_p[6];
    w_dec[5] = w_p[5] & ~w_p[7];
    w_dec[6] = w_p[7] & w_p[5];
    w_dec[7] = w_p[7] & w_p[2];
  end

  assign w_level    = r_wr - r_rd;
  assign w_full     = (w_level == FIFO_CAP);
  assign evt_valid  = (r_wr != r_rd);
  assign w_pop      = evt_valid & evt_ready;
  assign w_push_req = (w_dec != r_joy);
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 8'hFF;
      r_sync2    <= 8'hFF;
      r_div      <= '0;
      r_cand     <= 8'hFF;
      r_cnt      <= '0;
      r_accepted <= 8'hFF;
      r_joy      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
      r_div   <= w_strobe ? '0 : r_div + CW'(1);
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) r_accepted <= w_cand_nxt;
      r_joy <= w_dec;
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= w_dec;
        r_wr <= r_wr + (AW + 1)'(1);
      end
      if (w_pop) r_rd <= r_rd + (AW + 1)'(1);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  assign joy_out      = r_joy;
  assign evt_data     = r_mem[r_rd[AW-1:0]];
  assign evt_overflow = r_overflow;

endmodule

// File: tb/tb_aq_pad_decoder.sv
// Directed bench for aq_pad_decoder: a sample-history model predicts every output each cycle,
// and literal checks pin the decode table, latency and FIFO behaviour.
module tb_aq_pad_decoder;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] pad_in;
  logic [7:0] joy_out;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic       evt_overflow;

  int n_vec = 0;
  int n_bad = 0;

  aq_pad_decoder #(.SAMPLE_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .reset        (reset),
    .pad_in       (pad_in),
    .joy_out      (joy_out),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [7:0] m_pads[$];
  logic [7:0] m_samps[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_acc;
  logic [7:0] m_joy;
  logic       m_ovf;
  int         m_e;
  bit         m_started = 1'b0;

  function automatic logic [7:0] decode(input logic [7:0] acc);
    logic [7:0] p;
    logic [7:0] d;
    p    = ~acc;
    d[0] = p[1];
    d[1] = p[3];
    d[2] = p[0];
    d[3] = p[2] & ~p[7];
    d[4] = p[6];
    d[5] = p[5] & ~p[7];
    d[6] = p[7] & p[5];
    d[7] = p[7] & p[2];
    return d;
  endfunction

  // A byte is accepted once the last DB samples all agree.
  always @(posedge clk) begin
    logic [7:0] sync_val;
    logic [7:0] old_acc;
    logic [7:0] old_joy;
    bit         same;
    bit         do_pop;
    bit         was_full;
    m_started = 1'b1;
    if (reset) begin
      m_pads  = {};
      m_samps = {};
      exp_q   = {};
      m_acc   = 8'hFF;
      m_joy   = 8'h00;
      m_ovf   = 1'b0;
      m_e     = 0;
    end else begin
      sync_val = (m_pads.size() >= 2) ? m_pads[m_pads.size()-2] : 8'hFF;
      old_acc  = m_acc;
      old_joy  = m_joy;
      if (m_e % SD == SD - 1) begin
        m_samps.push_back(sync_val);
        if (m_samps.size() > DB) void'(m_samps.pop_front());
        if (m_samps.size() == DB) begin
          same = 1'b1;
          for (int i = 0; i < DB; i++) if (m_samps[i] != sync_val) same = 1'b0;
          if (same) m_acc = sync_val;
        end
      end
      m_pads.push_back(pad_in);
      if (m_pads.size() > 4) void'(m_pads.pop_front());
      m_joy    = decode(old_acc);
      do_pop   = (exp_q.size() != 0) && evt_ready;
      was_full = (exp_q.size() == FD);
      if (do_pop) void'(exp_q.pop_front());
      if (m_joy != old_joy) begin
        if (was_full && !do_pop) m_ovf = 1'b1;
        else exp_q.push_back(m_joy);
      end
      m_e++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (m_started) begin
      chk("joy_out", joy_out, m_joy);
      chk("evt_valid", {7'b0, evt_valid}, {7'b0, exp_q.size() != 0});
      chk("evt_overflow", {7'b0, evt_overflow}, {7'b0, m_ovf});
      if (exp_q.size() != 0) chk("evt_data", evt_data, exp_q[0]);
    end
  end

  // driver tasks
  task automatic hold_pad(input logic [7:0] v, input int cycles);
    @(negedge clk);
    pad_in = v;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic pop_one(input logic [7:0] exp);
    @(negedge clk);
    chk("pop_valid", {7'b0, evt_valid}, 8'h01);
    chk("pop_data", evt_data, exp);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] pads3 [5];
    logic [7:0] joys3 [5];
    logic [7:0] pads5 [5];
    int         guard;
    pads3 = '{8'h5F, 8'hDF, 8'h7B, 8'h5B, 8'h7F};
    joys3 = '{8'h40, 8'h20, 8'h80, 8'hC0, 8'h00};
    pads5 = '{8'hFD, 8'hF7, 8'hFE, 8'hFB, 8'hBF};

    reset = 1'b1;
    pad_in = 8'hFD;
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_joy", joy_out, 8'h00);
    chk("reset_data", evt_data, 8'h00);
    reset = 1'b0;

    // pad held from the first cycle: accepted on the strobe at edge 11, visible after edge 12
    repeat (12) @(negedge clk);
    chk("lat_before", joy_out, 8'h00);
    @(negedge clk);
    chk("lat_after", joy_out, 8'h01);
    repeat (10) @(negedge clk);
    pop_one(8'h01);
    chk("single_event", {7'b0, evt_valid}, 8'h00);

    // decode table
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hold_pad(pads3[i], 24);
      chk("decode", joy_out, joys3[i]);
    end

    // glitch of exactly two strobes
    evt_ready = 1'b0;
    hold_pad(8'hF7, 8);
    hold_pad(8'hFF, 24);
    chk("glitch_joy", joy_out, 8'h00);
    chk("glitch_noevt", {7'b0, evt_valid}, 8'h00);

    // overflow with five changes and no consumer
    for (int i = 0; i < 5; i++) hold_pad(pads5[i], 24);
    chk("ovf_set", {7'b0, evt_overflow}, 8'h01);
    pop_one(8'h01);
    pop_one(8'h02);
    pop_one(8'h04);
    pop_one(8'h08);
    chk("ovf_drained", {7'b0, evt_valid}, 8'h00);

    // reset with two events pending
    hold_pad(8'hFD, 24);
    hold_pad(8'hF7, 24);
    chk("pre_reset_valid", {7'b0, evt_valid}, 8'h01);
    reset = 1'b1;
    pad_in = 8'hFF;
    @(negedge clk);
    chk("mid_reset_joy", joy_out, 8'h00);
    chk("mid_reset_valid", {7'b0, evt_valid}, 8'h00);
    chk("mid_reset_ovf", {7'b0, evt_overflow}, 8'h00);
    chk("mid_reset_data", evt_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // full FIFO with a pop coinciding with the push
    for (int i = 0; i < 4; i++) hold_pad(pads5[i], 24);
    @(negedge clk);
    pad_in = 8'hBF;
    guard = 0;
    while (decode(m_acc) == m_joy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 64) begin
      n_bad++;
      $display("FAIL push_wait: got no push within 64 cycles, expected one");
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("full_pop_push_ovf", {7'b0, evt_overflow}, 8'h00);
    pop_one(8'h02);
    pop_one(8'h04);
    pop_one(8'h08);
    pop_one(8'h10);
    chk("full_pop_push_empty", {7'b0, evt_valid}, 8'h00);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
